chunked_adder_sequencer: RTL

- Multi-cycle adder that reuses one CHUNK-bit carry-lookahead group over the full WIDTH-bit operands, one chunk per clock, LSB chunk first.
- Serves area-constrained ALU paths that trade latency for a single lookahead group.
- Sequences the group with a chunk counter and a registered inter-chunk carry.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/chunked_adder_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one CHUNK-bit carry-lookahead group,
// one chunk per clock from the LSB chunk up, with valid/ready handshakes on both sides.
module chunked_adder_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             valid_out,
  input  logic             ack_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             overflow_out,
  output logic             pg_out
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_adder_sequencer: WIDTH must be a multiple of CHUNK");
  end

  // state | meaning
  // IDLE  | ready for operands
  // RUN   | one chunk added per cycle, LSB chunk first
  // DONE  | result presented, held until ack_in
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_acc, sum_full;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg, pg_acc;
  logic [CHUNK-1:0] p, g, s;
  logic [CHUNK:0]   c;
  logic             group_p, last_chunk, prop, term;

  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  // Flattened sum-of-products lookahead: every carry depends only on p/g and the chunk carry-in.
  always_comb begin
    prop     = 1'b0;
    term     = 1'b0;
    p        = a_reg[int'(cnt)*CHUNK +: CHUNK] ^ b_reg[int'(cnt)*CHUNK +: CHUNK];
    g        = a_reg[int'(cnt)*CHUNK +: CHUNK] & b_reg[int'(cnt)*CHUNK +: CHUNK];
    c        = '0;
    c[0]     = carry_reg;
    for (int i = 0; i < CHUNK; i++) begin
      prop = p[i];
      term = g[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & carry_reg);
    end
    s        = p ^ c[CHUNK-1:0];
    group_p  = &p;
    sum_full = sum_acc;
    sum_full[int'(cnt)*CHUNK +: CHUNK] = s;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_out  = 1'b0;
    valid_out  = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (start_in) state_next = RUN;
      end
      RUN:  if (last_chunk) state_next = DONE;
      DONE: begin
        valid_out = 1'b1;
        if (ack_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_acc      <= '0;
      cnt          <= '0;
      carry_reg    <= 1'b0;
      pg_acc       <= 1'b0;
      sum_out      <= '0;
      c_out        <= 1'b0;
      overflow_out <= 1'b0;
      pg_out       <= 1'b0;
    end else if (state == IDLE && start_in) begin
      a_reg     <= a_in;
      b_reg     <= b_in;
      carry_reg <= c_in;
      sum_acc   <= '0;
      cnt       <= '0;
      pg_acc    <= 1'b1;
    end else if (state == RUN) begin
      sum_acc   <= sum_full;
      carry_reg <= c[CHUNK];
      pg_acc    <= pg_acc & group_p;
      if (last_chunk) begin
        cnt          <= '0;
        sum_out      <= sum_full;
        c_out        <= c[CHUNK];
        overflow_out <= c[CHUNK-1] ^ c[CHUNK];
        pg_out       <= pg_acc & group_p;
      end else begin
        cnt <= CNT_W'(cnt + 1'b1);
      end
    end
  end

endmodule
